sample_streamer: RTL and testbench
==================================

# sample_streamer

Upstream stage of the linear-regression coefficient calculator. It buffers DEPTH (x, y) sample pairs written by the host. On start it replays the whole set PASSES times onto x_bus/y_bus, with a qualifying en strobe and a cout strobe on the last sample of each pass. These are exactly the signals the coefficient calculator consumes for its mean pass and its sum-of-products pass.

## Interface
- DATA_W, 20: width of each x and y sample (matches coefficient datapath word).
- DEPTH, 150: number of sample pairs per data set; must be at least 2.
- PASSES, 2: number of full replays per start; must be at least 1.
- ADDR_W, 8: pointer width; must satisfy 2^ADDR_W ≥ DEPTH.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: empties the buffer and aborts any stream.
- wr_en  input  1  write strobe for one sample pair.
- wr_x  input  DATA_W  x sample written when wr_en=1.
- wr_y  input  DATA_W  y sample written when wr_en=1.
- start  input  1  begin streaming; honoured only when idle and full.
- full  output  1  buffer holds DEPTH pairs.
- busy  output  1  high from the cycle after an accepted start until done.
- x_bus  output  DATA_W  streamed x sample, registered.
- y_bus  output  DATA_W  streamed y sample, registered.
- en  output  1  x_bus/y_bus carry a valid sample this cycle.
- cout  output  1  the current sample is the last (index DEPTH-1) of a pass.
- done  output  1  one-cycle pulse after the final sample of the final pass.

## Operation
- Storage: two DEPTH×DATA_W arrays (x, y). Array contents are not reset. The write count wr_cnt and all control state are reset.
- States:
  - IDLE: accepts writes.
  - STREAM: drives samples.
  - GAP: one bubble cycle between passes.
  - FIN: asserts done.
- IDLE behaviour:
  - wr_en=1 with wr_cnt<DEPTH stores (wr_x, wr_y) at index wr_cnt and increments wr_cnt.
  - full = (wr_cnt==DEPTH).
  - wr_en while full is ignored; stored data is unchanged.
- IDLE→STREAM: start=1 and full=1. Resets rd_ptr=0 and pass_cnt=0. A start without full is ignored.
- STREAM behaviour:
  - Each cycle, x_bus/y_bus present entry rd_ptr with en=1, then rd_ptr increments.
  - cout=1 when rd_ptr==DEPTH-1.
  - At the last sample: if pass_cnt<PASSES-1, go to GAP and increment pass_cnt; otherwise go to FIN.
- GAP: en=0, cout=0, x_bus/y_bus=0, rd_ptr=0. Next state is STREAM.
- FIN: done=1 for one cycle, busy=0, then IDLE. The buffer stays full, so start may replay the same data.
- wr_en outside IDLE is ignored.
- start outside IDLE is ignored.
- clr, in any state:
  - Next cycle: IDLE with wr_cnt=0, full=0, and en/cout/done/busy=0.
  - x_bus/y_bus return to 0.
  - clr has priority over a simultaneous wr_en or start.
- Whenever en=0, x_bus/y_bus are driven to 0. Data passes through unmodified: no arithmetic, no sign handling.

## Timing
- Reset values:
  - x_bus=0, y_bus=0.
  - en=0, cout=0, done=0, busy=0, full=0.
  - State IDLE, wr_cnt=0.
- Write latency: with a write on cycle w, full rises at w+1 when that write is the DEPTH-th.
- Start accepted at cycle t:
  - busy=1 from t+1.
  - Sample k of pass p appears at cycle t+1+p·(DEPTH+1)+k with en=1.
  - cout is high at k=DEPTH-1.
  - The GAP cycle follows each non-final pass.
- done fires at cycle t+1+PASSES·(DEPTH+1)-1, i.e. the cycle after the final cout. busy falls in that same cycle.
- A new start is accepted at the earliest in the cycle after done.
- Reset mid-stream: outputs go to reset values immediately (asynchronously). Streaming does not resume after reset release.

## Test plan
- Reset then fill: write 150 pairs with x=i, y=2i+1.
  - full rises the cycle after the 150th write.
  - A 151st write (x=999) is ignored, and entry 149 still reads back as x=149.
- Start with DEPTH=150, PASSES=2:
  - en is high for 150 cycles, then one low cycle, then 150 more.
  - x_bus sequence is 0..149 twice; y_bus=2x+1.
  - cout is high exactly twice, both with x_bus=149.
  - done pulses once, at t+302.
- start while not full (wr_cnt=10): no en, busy stays 0. Writes continue normally.
- clr at pass 1, sample 40:
  - Next cycle en=0, x_bus=0, busy=0, full=0.
  - A subsequent start is ignored until 150 new writes are made.
- Async reset asserted mid-pass: all outputs are 0 in the same cycle. After release the block sits in IDLE with full=0.
- Replay: after done, start again with no writes. The identical two-pass stream repeats, and start pulses during streaming have no effect.

Source files
------------

// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - buffers DEPTH (x, y) sample pairs and replays them PASSES times
module sample_streamer #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 150,
    parameter int PASSES = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    input  logic              start,
    output logic              full,
    output logic              busy,
    output logic [DATA_W-1:0] x_bus,
    output logic [DATA_W-1:0] y_bus,
    output logic              en,
    output logic              cout,
    output logic              done
);

    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    // write count needs one extra bit so it can hold DEPTH itself
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        FIN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem_x [DEPTH];
    logic [DATA_W-1:0] mem_y [DEPTH];
    logic [ADDR_W:0]   wr_cnt;
    // index of the entry to be presented next
    logic [ADDR_W-1:0] rd_ptr;
    logic [PASS_W-1:0] pass_cnt;
    logic              wr_ok;

    assign full  = (wr_cnt == DEPTH_CNT);
    assign wr_ok = (state == IDLE) && !clr && wr_en && !full;

    // sample storage: written only while idle and not yet full, never reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_x[wr_cnt[ADDR_W-1:0]] <= wr_x;
            mem_y[wr_cnt[ADDR_W-1:0]] <= wr_y;
        end
    end

    // control FSM; outputs are registered so they always describe the current cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
            x_bus    <= '0;
            y_bus    <= '0;
            en       <= 1'b0;
            cout     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
            x_bus    <= '0;
            y_bus    <= '0;
            en       <= 1'b0;
            cout     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (wr_ok) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (start && full) begin
                        state    <= STREAM;
                        x_bus    <= mem_x[0];
                        y_bus    <= mem_y[0];
                        en       <= 1'b1;
                        cout     <= 1'b0;
                        busy     <= 1'b1;
                        rd_ptr   <= ADDR_W'(1);
                        pass_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (cout) begin
                        // the last sample of the pass was shown this cycle
                        en     <= 1'b0;
                        cout   <= 1'b0;
                        x_bus  <= '0;
                        y_bus  <= '0;
                        rd_ptr <= '0;
                        if (pass_cnt != LAST_PASS) begin
                            pass_cnt <= pass_cnt + 1'b1;
                            state    <= GAP;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        x_bus  <= mem_x[rd_ptr];
                        y_bus  <= mem_y[rd_ptr];
                        en     <= 1'b1;
                        cout   <= (rd_ptr == LAST_IDX);
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                GAP: begin
                    state  <= STREAM;
                    x_bus  <= mem_x[0];
                    y_bus  <= mem_y[0];
                    en     <= 1'b1;
                    cout   <= 1'b0;
                    rd_ptr <= ADDR_W'(1);
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// tb/tb_sample_streamer.sv - directed and randomized checks of sample_streamer against a reference model
module tb_sample_streamer;

    localparam int DW = 20;
    localparam int D  = 150;
    localparam int P  = 2;
    localparam int AW = 8;

    typedef logic [2*DW+4:0] obs_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          clr   = 1'b0;
    logic          wr_en = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] wr_x  = '0;
    logic [DW-1:0] wr_y  = '0;
    logic          full, busy, en, cout, done;
    logic [DW-1:0] x_bus, y_bus;

    int tests = 0;
    int fails = 0;

    // reference model: stored pairs and how many are held
    logic [DW-1:0] mx [D];
    logic [DW-1:0] my [D];
    int            model_cnt = 0;

    sample_streamer #(.DATA_W(DW), .DEPTH(D), .PASSES(P), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .wr_en (wr_en),
        .wr_x  (wr_x),
        .wr_y  (wr_y),
        .start (start),
        .full  (full),
        .busy  (busy),
        .x_bus (x_bus),
        .y_bus (y_bus),
        .en    (en),
        .cout  (cout),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t pk(input bit b, input bit d, input bit c, input bit e, input bit f,
                                input logic [DW-1:0] x, input logic [DW-1:0] y);
        return {b, d, c, e, f, x, y};
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t o;
        o = {busy, done, cout, en, full, x_bus, y_bus};
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_pair(input logic [DW-1:0] x, input logic [DW-1:0] y);
        wr_en = 1'b1;
        wr_x  = x;
        wr_y  = y;
        tick();
        wr_en = 1'b0;
        if (model_cnt < D) begin
            mx[model_cnt] = x;
            my[model_cnt] = y;
            model_cnt++;
        end
    endtask

    // Start a run and follow every cycle up to the idle cycle after done.
    // clr_at > 0 raises clr (together with start/wr_en) on that cycle.
    task automatic run_stream(input int clr_at, input bit noise);
        int   p, k;
        obs_t e;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= P * (D + 1) + 1; c++) begin
            p = (c - 1) / (D + 1);
            k = (c - 1) % (D + 1);
            if (c == P * (D + 1))          e = pk(0, 1, 0, 0, 1, '0, '0);
            else if (c == P * (D + 1) + 1) e = pk(0, 0, 0, 0, 1, '0, '0);
            else if (k < D)                e = pk(1, 0, k == D - 1, 1, 1, mx[k], my[k]);
            else                           e = pk(1, 0, 0, 0, 1, '0, '0);
            check($sformatf("stream p=%0d k=%0d", p, k), e);
            if (c == clr_at) begin
                clr   = 1'b1;
                start = 1'b1;
                wr_en = 1'b1;
                tick();
                clr   = 1'b0;
                start = 1'b0;
                wr_en = 1'b0;
                model_cnt = 0;
                check("clr next cycle", pk(0, 0, 0, 0, 0, '0, '0));
                return;
            end
            if (c <= P * (D + 1)) begin
                if (noise) begin
                    start = 1'($urandom);
                    wr_en = 1'($urandom);
                    wr_x  = DW'($urandom);
                    wr_y  = DW'($urandom);
                end
                tick();
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #12;
        check("reset state", pk(0, 0, 0, 0, 0, '0, '0));
        rst = 1'b1;
        tick();
        check("idle after reset", pk(0, 0, 0, 0, 0, '0, '0));

        // deterministic fill x=i, y=2i+1
        for (int i = 0; i < D; i++) begin
            write_pair(DW'(i), DW'(2 * i + 1));
            if (i == D - 2) check("not full after 149 writes", pk(0, 0, 0, 0, 0, '0, '0));
        end
        check("full after 150th write", pk(0, 0, 0, 0, 1, '0, '0));
        write_pair(DW'(999), DW'(7));
        check("write while full ignored", pk(0, 0, 0, 0, 1, '0, '0));

        // plain stream, then replay with random start/wr_en noise
        run_stream(-1, 1'b0);
        run_stream(-1, 1'b1);

        // clear at pass 1 sample 40
        run_stream(1 + (D + 1) + 40, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start after clr ignored", pk(0, 0, 0, 0, 0, '0, '0));
        tick();
        check("still idle after clr", pk(0, 0, 0, 0, 0, '0, '0));

        // start while only 10 pairs held
        for (int i = 0; i < 10; i++) write_pair(DW'($urandom), DW'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start not full ignored", pk(0, 0, 0, 0, 0, '0, '0));
        tick();
        check("no stream when not full", pk(0, 0, 0, 0, 0, '0, '0));
        for (int i = 10; i < D; i++) write_pair(DW'($urandom), DW'($urandom));
        check("full after random fill", pk(0, 0, 0, 0, 1, '0, '0));
        run_stream(-1, 1'b1);

        // asynchronous reset in the middle of pass 0
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("mid-stream before reset", pk(1, 0, 0, 1, 1, mx[60], my[60]));
        #2 rst = 1'b0;
        #1;
        check("async reset immediate", pk(0, 0, 0, 0, 0, '0, '0));
        model_cnt = 0;
        tick();
        rst = 1'b1;
        tick();
        check("idle after reset release", pk(0, 0, 0, 0, 0, '0, '0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("no resume after reset", pk(0, 0, 0, 0, 0, '0, '0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
